// File: rtl/sdram_pkg.sv
// Shared SDRAM sequencer definitions: command encodings, FSM states, parameter legality.
package sdram_pkg;

    typedef logic [3:0] cmd_t;   // {Cs_n, Ras_n, Cas_n, We_n}

    localparam cmd_t C_NOP = 4'b0111;
    localparam cmd_t C_ACT = 4'b0011;
    localparam cmd_t C_RD  = 4'b0101;
    localparam cmd_t C_WR  = 4'b0100;
    localparam cmd_t C_PRE = 4'b0010;

    localparam int DLY_W = 16;

    typedef enum logic [3:0] {
        S_IDLE, S_ACT, S_RCD, S_CMD, S_BURST, S_WREC, S_PRE, S_RP, S_DONE
    } state_t;

    function automatic bit cfg_legal(input int row_w, input int col_w, input int t_rcd,
                                     input int t_wr, input int t_rp, input int cas_lat,
                                     input int burst_len);
        return (row_w >= 11) && (col_w <= 10) &&
               (t_rcd >= 1) && (t_rcd <= 65536) &&
               (t_wr >= 1) && (t_wr <= 65536) &&
               (t_rp >= 1) && (t_rp <= 65536) &&
               ((cas_lat == 2) || (cas_lat == 3)) &&
               (burst_len >= 1) && (burst_len <= 256);
    endfunction

endpackage

// File: rtl/sdram_delay_cnt.sv
// Loadable down-counter that parks at zero; zero flag is combinational from the count.
// Shared by the RCD, write-recovery and precharge waits.
module sdram_delay_cnt #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sdram_burst_seq.sv
// Single-bank SDRAM read/write burst sequencer; ACT one cycle after accept, all outputs registered.
// One request at a time: Req is only taken in IDLE/DONE, anything else is dropped.
module sdram_burst_seq
    import sdram_pkg::*;
#(
    parameter int ROW_W     = 13,
    parameter int COL_W     = 9,
    parameter int BA_W      = 2,
    parameter int T_RCD     = 2,
    parameter int T_WR      = 2,
    parameter int T_RP      = 2,
    parameter int CAS_LAT   = 3,
    parameter int BURST_LEN = 4,
    parameter int AUTO_PRE  = 0
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Req,
    input  logic             Req_wr,
    input  logic [BA_W-1:0]  Req_bank,
    input  logic [ROW_W-1:0] Req_row,
    input  logic [COL_W-1:0] Req_col,
    output logic             Req_ready,
    output logic             Cs_n,
    output logic             Ras_n,
    output logic             Cas_n,
    output logic             We_n,
    output logic [ROW_W-1:0] Sa,
    output logic [BA_W-1:0]  Ba,
    output logic             Wr_data_valid,
    output logic             Rd_data_valid,
    output logic             Done
);

    if (!cfg_legal(ROW_W, COL_W, T_RCD, T_WR, T_RP, CAS_LAT, BURST_LEN)) begin : g_cfg_err
        $error("sdram_burst_seq: illegal parameter set");
    end

    localparam int       RCD_LOAD = (T_RCD > 1) ? T_RCD - 2 : 0;
    localparam int       RP_LOAD  = (T_RP > 1) ? T_RP - 2 : 0;
    localparam logic [8:0] BL9    = 9'(BURST_LEN);

    state_t             state, nxt;
    cmd_t               cmd_q, cmd_n;
    logic [ROW_W-1:0]   sa_n;
    logic [BA_W-1:0]    ba_n;
    logic               wrv_n, rda_n, rd_act;
    logic               wr_q;
    logic [BA_W-1:0]    bank_q;
    logic [COL_W-1:0]   col_q;
    logic [8:0]         beat;
    logic [CAS_LAT-1:0] rd_sr;
    logic               rd_pend, accept;
    logic               dly_load, dly_zero;
    logic [DLY_W-1:0]   dly_val;

    assign accept  = Req && Req_ready;
    // Read beats still in the CAS pipeline beyond the one on the bus now.
    assign rd_pend = rd_act | (|rd_sr[CAS_LAT-2:0]);

    sdram_delay_cnt #(.W(DLY_W)) u_dly (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .load  (dly_load),
        .value (dly_val),
        .zero  (dly_zero)
    );

    always_comb begin
        nxt      = state;
        dly_load = 1'b0;
        dly_val  = '0;
        case (state)
            S_IDLE, S_DONE: nxt = Req ? S_ACT : S_IDLE;
            S_ACT: begin
                if (T_RCD == 1) begin
                    nxt = S_CMD;
                end else begin
                    nxt      = S_RCD;
                    dly_load = 1'b1;
                    dly_val  = DLY_W'(RCD_LOAD);
                end
            end
            S_RCD:  if (dly_zero) nxt = S_CMD;
            S_CMD, S_BURST: begin
                if (beat == BL9) begin
                    if (wr_q) begin
                        nxt      = S_WREC;
                        dly_load = 1'b1;
                        dly_val  = DLY_W'(T_WR - 1);
                    end else begin
                        nxt = S_PRE;
                    end
                end else begin
                    nxt = S_BURST;
                end
            end
            S_WREC: if (dly_zero) nxt = S_PRE;
            S_PRE: begin
                if (T_RP == 1 && !rd_pend) begin
                    nxt = S_DONE;
                end else begin
                    nxt      = S_RP;
                    dly_load = 1'b1;
                    dly_val  = DLY_W'(RP_LOAD);
                end
            end
            S_RP:   if (dly_zero && !rd_pend) nxt = S_DONE;
            default: nxt = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        cmd_n = C_NOP;
        sa_n  = '0;
        ba_n  = '0;
        case (nxt)
            S_ACT: begin
                cmd_n = C_ACT;
                sa_n  = Req_row;
                ba_n  = Req_bank;
            end
            S_CMD: begin
                cmd_n    = wr_q ? C_WR : C_RD;
                sa_n     = ROW_W'(col_q);
                sa_n[10] = (AUTO_PRE != 0);
                ba_n     = bank_q;
            end
            S_PRE: begin
                if (AUTO_PRE == 0) begin
                    cmd_n    = C_PRE;
                    sa_n[10] = 1'b1;
                    ba_n     = bank_q;
                end
            end
            default: ;
        endcase
        wrv_n = (nxt == S_CMD || nxt == S_BURST) && wr_q;
        rda_n = (nxt == S_CMD || nxt == S_BURST) && !wr_q;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state         <= S_IDLE;
            cmd_q         <= C_NOP;
            Sa            <= '0;
            Ba            <= '0;
            Wr_data_valid <= 1'b0;
            rd_act        <= 1'b0;
            rd_sr         <= '0;
            Done          <= 1'b0;
            Req_ready     <= 1'b1;
            wr_q          <= 1'b0;
            bank_q        <= '0;
            col_q         <= '0;
            beat          <= '0;
        end else begin
            state         <= nxt;
            cmd_q         <= cmd_n;
            Sa            <= sa_n;
            Ba            <= ba_n;
            Wr_data_valid <= wrv_n;
            rd_act        <= rda_n;
            rd_sr         <= {rd_sr[CAS_LAT-2:0], rd_act};
            Done          <= (nxt == S_DONE);
            Req_ready     <= (nxt == S_IDLE) || (nxt == S_DONE);
            if (accept) begin
                wr_q   <= Req_wr;
                bank_q <= Req_bank;
                col_q  <= Req_col;
            end
            if (nxt == S_CMD)
                beat <= 9'd1;
            else if (nxt == S_BURST && beat < BL9)
                beat <= beat + 1'b1;
        end
    end

    assign {Cs_n, Ras_n, Cas_n, We_n} = cmd_q;
    assign Rd_data_valid = rd_sr[CAS_LAT-1];

endmodule

// File: tb/tb_sdram_burst_seq.sv
// Bench for sdram_burst_seq: four parameterisations driven with directed and random bursts,
// every cycle compared against event times computed from the timing formulas.
`timescale 1ns/1ps
module tb_sdram_burst_seq;
    import sdram_pkg::*;

    localparam int N    = 4;
    localparam int AP [N] = '{0, 1, 0, 0};
    localparam int BLS[N] = '{4, 4, 1, 256};
    localparam int CLS[N] = '{3, 3, 2, 2};
    localparam int TRCD = 2;
    localparam int TWR  = 2;
    localparam int TRP  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req[N], req_wr[N];
    logic [1:0]  req_bank[N];
    logic [12:0] req_row[N];
    logic [8:0]  req_col[N];
    logic        req_ready[N], cs_n[N], ras_n[N], cas_n[N], we_n[N];
    logic [12:0] sa[N];
    logic [1:0]  ba[N];
    logic        wr_v[N], rd_v[N], done[N];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        sdram_burst_seq #(
            .AUTO_PRE  (AP[g]),
            .BURST_LEN (BLS[g]),
            .CAS_LAT   (CLS[g])
        ) u_dut (
            .Clk           (clk),
            .Rst_n         (rst_n),
            .Req           (req[g]),
            .Req_wr        (req_wr[g]),
            .Req_bank      (req_bank[g]),
            .Req_row       (req_row[g]),
            .Req_col       (req_col[g]),
            .Req_ready     (req_ready[g]),
            .Cs_n          (cs_n[g]),
            .Ras_n         (ras_n[g]),
            .Cas_n         (cas_n[g]),
            .We_n          (we_n[g]),
            .Sa            (sa[g]),
            .Ba            (ba[g]),
            .Wr_data_valid (wr_v[g]),
            .Rd_data_valid (rd_v[g]),
            .Done          (done[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] vec(input int g);
        return {cs_n[g], ras_n[g], cas_n[g], we_n[g], wr_v[g], rd_v[g], done[g], req_ready[g]};
    endfunction

    function automatic logic [7:0] mk(input logic [3:0] c, input bit w, input bit r,
                                      input bit d, input bit rdy);
        return {c, w, r, d, rdy};
    endfunction

    task automatic scramble(input int g);
        req[g]      = 1'($urandom_range(0, 1));
        req_wr[g]   = 1'($urandom);
        req_bank[g] = 2'($urandom);
        req_row[g]  = 13'($urandom);
        req_col[g]  = 9'($urandom);
    endtask

    // Called at a negedge where the DUT should be ready; that cycle is c0.
    task automatic burst(input int g, input bit wr, input logic [1:0] bank,
                         input logic [12:0] row, input logic [8:0] col, input bit hold);
        int cmdc, last, pre, rdf, rdl, dn, beats;
        logic [12:0] esa;
        logic [3:0]  ec;
        cmdc = 1 + TRCD;
        last = TRCD + BLS[g];
        pre  = wr ? 1 + TRCD + BLS[g] + TWR : 1 + TRCD + BLS[g];
        rdf  = 1 + TRCD + CLS[g];
        rdl  = TRCD + CLS[g] + BLS[g];
        dn   = pre + TRP;
        if (!wr && rdl + 1 > dn) dn = rdl + 1;
        beats = 0;
        chk($sformatf("u%0d ready_c0", g), 32'(req_ready[g]), 32'(1));
        req[g] = 1'b1; req_wr[g] = wr; req_bank[g] = bank; req_row[g] = row; req_col[g] = col;
        for (int k = 1; k <= dn; k++) begin
            @(posedge clk);
            @(negedge clk);
            ec = C_NOP;
            if (k == 1) ec = C_ACT;
            else if (k == cmdc) ec = wr ? C_WR : C_RD;
            else if (k == pre && AP[g] == 0) ec = C_PRE;
            chk($sformatf("u%0d c%0d outs", g, k), 32'(vec(g)),
                32'(mk(ec, wr && k >= cmdc && k <= last, !wr && k >= rdf && k <= rdl,
                       k == dn, k == dn)));
            if (rd_v[g]) beats++;
            if (k == 1) begin
                chk($sformatf("u%0d act_sa", g), 32'(sa[g]), 32'(row));
                chk($sformatf("u%0d act_ba", g), 32'(ba[g]), 32'(bank));
            end
            if (k == cmdc) begin
                esa = 13'(col);
                esa[10] = (AP[g] != 0);
                chk($sformatf("u%0d cmd_sa", g), 32'(sa[g]), 32'(esa));
                chk($sformatf("u%0d cmd_ba", g), 32'(ba[g]), 32'(bank));
            end
            if (k == pre && AP[g] == 0) begin
                chk($sformatf("u%0d pre_a10", g), 32'(sa[g][10]), 32'(1));
                chk($sformatf("u%0d pre_ba", g), 32'(ba[g]), 32'(bank));
            end
            if (k < dn) scramble(g);
            else req[g] = hold;
        end
        if (!wr) chk($sformatf("u%0d rd_beats", g), 32'(beats), 32'(BLS[g]));
    endtask

    task automatic idle(input int g, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("u%0d idle", g), 32'(vec(g)), 32'(mk(C_NOP, 1'b0, 1'b0, 1'b0, 1'b1)));
        end
    endtask

    initial begin
        bit hold;
        for (int g = 0; g < N; g++) begin
            req[g] = 1'b0; req_wr[g] = 1'b0; req_bank[g] = '0; req_row[g] = '0; req_col[g] = '0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < N; g++) begin
            chk($sformatf("u%0d rst_outs", g), 32'(vec(g) >> 1), 32'({C_NOP, 3'b000}));
            chk($sformatf("u%0d rst_sa", g), 32'(sa[g]), 32'(0));
            chk($sformatf("u%0d rst_ba", g), 32'(ba[g]), 32'(0));
        end
        rst_n = 1'b1;
        idle(0, 2);

        // Directed default write and read
        burst(0, 1'b1, 2'd2, 13'h1A5, 9'h003, 1'b0);
        idle(0, 2);
        burst(0, 1'b0, 2'd1, 13'h0F0, 9'h011, 1'b0);
        idle(0, 1);

        // Random traffic, some of it back-to-back with Req held through Done
        for (int i = 0; i < 10; i++) begin
            hold = (i < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
            burst(0, 1'($urandom), 2'($urandom), 13'($urandom), 9'($urandom), hold);
            if (!hold) idle(0, $urandom_range(1, 3));
        end

        // Auto-precharge
        burst(1, 1'b1, 2'd3, 13'h0AA, 9'h1FF, 1'b1);
        burst(1, 1'b0, 2'($urandom), 13'($urandom), 9'($urandom), 1'b0);
        idle(1, 2);

        // Single-beat and 256-beat bursts at CAS 2
        burst(2, 1'b0, 2'd0, 13'h1234, 9'h0, 1'b0);
        idle(2, 1);
        burst(2, 1'b1, 2'($urandom), 13'($urandom), 9'($urandom), 1'b0);
        idle(2, 1);
        burst(3, 1'b0, 2'd1, 13'h0777, 9'h100, 1'b0);
        idle(3, 3);

        // Reset in the middle of a default read
        req[0] = 1'b1; req_wr[0] = 1'b0; req_bank[0] = 2'd3; req_row[0] = 13'h55; req_col[0] = 9'h7;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            req[0] = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("u0 midrst_outs", 32'(vec(0) >> 1), 32'({C_NOP, 3'b000}));
        chk("u0 midrst_sa", 32'(sa[0]), 32'(0));
        chk("u0 midrst_ba", 32'(ba[0]), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(0, 6);
        burst(0, 1'($urandom), 2'($urandom), 13'($urandom), 9'($urandom), 1'b0);
        idle(0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
